// File: rtl/bp_be_fe_replay_queue.sv
// bp_be_fe_replay_queue: FE packet queue that keeps issued entries until commit so they can be replayed.
module bp_be_fe_replay_queue #(
  parameter int els_p   = 8,
  parameter int width_p = 128
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [width_p-1:0]      fe_queue_i,
  input  logic                    fe_queue_v_i,
  output logic                    fe_queue_ready_o,
  output logic [width_p-1:0]      fe_queue_o,
  output logic                    fe_queue_v_o,
  input  logic                    fe_queue_yumi_i,
  input  logic                    clr_v_i,
  input  logic                    deq_v_i,
  input  logic                    roll_v_i,
  output logic [$clog2(els_p):0]  count_o
);
  localparam int lg_lp = $clog2(els_p);
  localparam int pw_lp = lg_lp + 1;
  logic [width_p-1:0] r_mem [els_p];
  logic [lg_lp:0] r_wptr, r_rptr, r_cptr;
  logic [lg_lp:0] w_wptr_n, w_rptr_n, w_cptr_n;
  logic w_full, w_enq, w_iss;
  assign w_full = (r_wptr[lg_lp-1:0] == r_cptr[lg_lp-1:0]) && (r_wptr[lg_lp] != r_cptr[lg_lp]);
  assign fe_queue_ready_o = ~w_full;
  assign fe_queue_v_o = r_rptr != r_wptr;
  assign fe_queue_o = r_mem[r_rptr[lg_lp-1:0]];
  assign count_o = r_wptr - r_cptr;
  assign w_enq = fe_queue_v_i & ~w_full & ~clr_v_i;
  assign w_iss = fe_queue_yumi_i & ~clr_v_i & ~roll_v_i;
  // rewinds land on the commit pointer after any same-cycle commit
  always_comb begin
    w_cptr_n = r_cptr + pw_lp'(deq_v_i);
    w_rptr_n = (clr_v_i | roll_v_i) ? w_cptr_n : r_rptr + pw_lp'(w_iss);
    w_wptr_n = clr_v_i ? w_cptr_n : r_wptr + pw_lp'(w_enq);
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cptr <= '0;
    end else begin
      r_wptr <= w_wptr_n;
      r_rptr <= w_rptr_n;
      r_cptr <= w_cptr_n;
    end
  end
  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr[lg_lp-1:0]] <= fe_queue_i;
  end
  a_yumi_v: assert property (@(posedge clk_i) disable iff (!reset_n_i) fe_queue_yumi_i |-> fe_queue_v_o);
  a_deq_issued: assert property (@(posedge clk_i) disable iff (!reset_n_i) deq_v_i |-> (r_cptr != r_rptr));
endmodule

// File: doc/bp_be_fe_replay_queue.md
BP_BE_FE_REPLAY_QUEUE -- requirements
Module: bp_be_fe_replay_queue

Interface
REQ-001 SHALL have parameter els_p, default 8: entry count; power of two, minimum 2.
REQ-002 SHALL have parameter width_p, default 128: entry width, sized to one FE queue packet.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, named clk_i and reset_n_i.
REQ-004 clk_i  in  1  rising-edge clock.
REQ-005 reset_n_i  in  1  asynchronous active-low reset.
REQ-006 fe_queue_i  in  width_p  enqueue data from the front end.
REQ-007 fe_queue_v_i  in  1  enqueue valid.
REQ-008 fe_queue_ready_o  out  1  space available.
REQ-009 fe_queue_o  out  width_p  oldest unissued entry.
REQ-010 fe_queue_v_o  out  1  fe_queue_o is valid.
REQ-011 fe_queue_yumi_i  in  1  consumer takes fe_queue_o this cycle.
REQ-012 clr_v_i  in  1  flush all uncommitted entries (director).
REQ-013 deq_v_i  in  1  commit the oldest issued entry (commit pkt queue_v).
REQ-014 roll_v_i  in  1  rewind issue pointer to commit pointer (commit pkt npc_w_v).
REQ-015 count_o  out  $clog2(els_p)+1  entries between commit and write pointers.

Function
REQ-016 SHALL keep three pointers of $clog2(els_p)+1 bits each (index plus wrap bit): wptr (write), rptr (speculative issue), cptr (commit); ordering cptr <= rptr <= wptr modulo wrap.
REQ-017 Full SHALL be wptr and cptr with equal index and differing wrap bit; fe_queue_ready_o = ~full, registered-state only and independent of same-cycle inputs.
REQ-018 fe_queue_v_o SHALL equal (rptr != wptr) from registered state; fe_queue_o SHALL be mem[rptr index], read combinationally.
REQ-019 Enqueue fires when fe_queue_v_i & fe_queue_ready_o & ~clr_v_i: write mem[wptr], wptr += 1; the entry is visible on fe_queue_o the next cycle, giving 1-cycle minimum latency.
REQ-020 Issue fires when fe_queue_yumi_i & ~clr_v_i & ~roll_v_i: rptr += 1; the entry is retained until committed.
REQ-021 Commit fires on deq_v_i: cptr += 1, freeing one slot; fe_queue_ready_o may rise the next cycle.
REQ-022 Roll: rptr <= cptr_next, where cptr_next includes a same-cycle deq_v_i; a same-cycle yumi is ignored.
REQ-023 Clear: rptr <= cptr_next and wptr <= cptr_next; a same-cycle enqueue and yumi are dropped; a same-cycle deq_v_i still commits.
REQ-024 Priority SHALL be clr_v_i > roll_v_i > yumi; deq_v_i and enqueue are independent of each other and of roll.
REQ-025 Pointer increments SHALL wrap modulo 2*els_p through the wrap bit.
REQ-026 count_o SHALL be (wptr - cptr) modulo 2*els_p, ranging 0..els_p, from registered state.
REQ-027 Simultaneous enqueue and commit while full: the enqueue is not accepted, because ready_o was 0; the commit proceeds.
REQ-028 Simultaneous enqueue and yumi on a one-entry queue: both proceed; the new entry is visible next cycle.
REQ-029 SHALL assert in simulation: yumi without fe_queue_v_o; deq_v_i when cptr == rptr; roll_v_i and clr_v_i together is allowed (clr wins).

Reset
REQ-030 When reset_n_i is low, wptr, rptr and cptr SHALL clear to 0 immediately; fe_queue_v_o = 0, fe_queue_ready_o = 1, count_o = 0; mem contents are not reset.
REQ-031 Reset asserted mid-operation SHALL discard all entries, with no enqueue or commit taking effect in that cycle.
REQ-032 The first enqueue SHALL be accepted on the first rising edge after reset_n_i deasserts.

Verification (els_p = 4)
REQ-033 Fill: enqueue A,B,C,D with no yumi -> ready_o = 0 after D, count_o = 4, v_o = 1, fe_queue_o = A.
REQ-034 Replay: enqueue A,B,C; yumi A,B; deq once; roll -> next cycle fe_queue_o = B, count_o = 2, rptr = cptr = 1.
REQ-035 Clear: enqueue A,B,C; yumi A; clr_v_i together with fe_queue_v_i = 1 carrying E -> next cycle v_o = 0, count_o = 0, E absent.
REQ-036 Wrap: enqueue, yumi and deq 6 entries one per cycle -> data order preserved across the wrap, and ready_o never drops.
REQ-037 Deq plus roll: issued A,B; deq and roll in the same cycle -> next cycle fe_queue_o = B, count_o = 1.
REQ-038 Async reset: assert reset_n_i between clock edges while count_o = 3 -> outputs reach reset values before the next edge.
